// File: rtl/pc_hazard_ctrl.sv
// Fetch-stage sequencer for the 5-stage MIPS pipeline: PC write/select, IF/ID and ID/EX
// controls, load-use bubble insertion and saturating stall/flush statistics.
module pc_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             ex_is_beq,
    input  logic             ex_beq_taken,
    input  logic             id_is_j,
    input  logic             id_is_jr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    localparam logic [2:0]       BUBBLES_M1 = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state_reg, state_next;
    logic [2:0] bcnt_reg, bcnt_next;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));

    assign state = state_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            bcnt_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            bcnt_reg  <= bcnt_next;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_next  = state_reg;
        bcnt_next   = bcnt_reg;
        if (!reset) begin
            // Both pipeline registers are bubbled while the core is held in reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = RUN;
            bcnt_next   = 3'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ext_stall) begin
                        // Full freeze: nothing moves, nothing is bubbled.
                    end else if (ex_is_beq && ex_beq_taken) begin
                        pc_src      = 2'b10;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        // Checked before jr because jr's rs may be the pending load result.
                        id_ex_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_next = LOAD_STALL;
                            bcnt_next  = BUBBLES_M1;
                        end
                    end else if (id_is_jr) begin
                        pc_src      = 2'b11;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (id_is_j) begin
                        pc_src      = 2'b01;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    if (!ext_stall) begin
                        id_ex_flush = 1'b1;
                        bcnt_next   = bcnt_reg - 3'd1;
                        if (bcnt_reg <= 3'd1) begin
                            state_next = RUN;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                    bcnt_next  = 3'd0;
                end
            endcase
        end
    end

    // Statistics sample the combinational decision of the cycle that ends at this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (clr_stats) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Scoreboard bench for pc_hazard_ctrl: directed scenarios then random traffic, checked
// against a cycle-level reference that tracks "remaining front-end hold cycles".
module tb_pc_hazard_ctrl;

    localparam int LB    = 3;
    localparam int CW    = 10;   // narrow counters so saturation is reached quickly
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          ext_stall, ex_is_beq, ex_beq_taken, id_is_j, id_is_jr;
    logic          id_uses_rs, id_uses_rt, ex_mem_read, clr_stats;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, state;
    logic [1:0]    pc_src;
    logic [CW-1:0] stall_cycles, flush_events;

    pc_hazard_ctrl #(.LOAD_BUBBLES(LB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .ex_is_beq(ex_is_beq),
        .ex_beq_taken(ex_beq_taken), .id_is_j(id_is_j), .id_is_jr(id_is_jr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .clr_stats(clr_stats),
        .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc_write;
        int pc_src;
        int if_id_write;
        int if_id_flush;
        int id_ex_flush;
        int state;
        int stall_cycles;
        int flush_events;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   failures = 0;
    int   txn      = 0;
    bit   quiet    = 0;

    // Reference state: hold cycles still owed to the current load-use hazard, and counters.
    int   hold     = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s (txn %0d): got %0d, expected %0d", name, txn, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!quiet)
                $display("[TB] txn %0d: rst=%0b pc_write=%0b pc_src=%0d if_id_write=%0b if_id_flush=%0b id_ex_flush=%0b state=%0b stalls=%0d flushes=%0d",
                         txn, reset, pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
                         state, stall_cycles, flush_events);
            chk("pc_write",     int'(pc_write),     e.pc_write);
            chk("pc_src",       int'(pc_src),       e.pc_src);
            chk("if_id_write",  int'(if_id_write),  e.if_id_write);
            chk("if_id_flush",  int'(if_id_flush),  e.if_id_flush);
            chk("id_ex_flush",  int'(id_ex_flush),  e.id_ex_flush);
            chk("state",        int'(state),        e.state);
            chk("stall_cycles", int'(stall_cycles), e.stall_cycles);
            chk("flush_events", int'(flush_events), e.flush_events);
            txn++;
        end
    end

    task automatic idle();
        reset = 1'b1; ext_stall = 0; ex_is_beq = 0; ex_beq_taken = 0; id_is_j = 0; id_is_jr = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
        clr_stats = 0;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then advance the model.
    task automatic step();
        exp_t e;
        bit   lu;
        int   nhold;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
        e = '{default: 0};
        e.state        = (hold > 0) ? 1 : 0;
        e.stall_cycles = m_stall;
        e.flush_events = m_flush;
        nhold = hold;
        if (!reset) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
            e.state = 0; e.stall_cycles = 0; e.flush_events = 0;
            nhold = 0;
        end else if (hold > 0) begin
            if (!ext_stall) begin
                e.id_ex_flush = 1;
                nhold = hold - 1;
            end
        end else if (ext_stall) begin
            nhold = 0;
        end else if (ex_is_beq && ex_beq_taken) begin
            e.pc_src = 2; e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (lu) begin
            e.id_ex_flush = 1;
            nhold = LB - 1;
        end else if (id_is_jr) begin
            e.pc_src = 3; e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1;
        end else if (id_is_j) begin
            e.pc_src = 1; e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1;
        end else begin
            e.pc_write = 1; e.if_id_write = 1;
        end
        q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            hold = 0; m_stall = 0; m_flush = 0;
        end else begin
            hold = nhold;
            if (clr_stats) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e.pc_write == 0 && m_stall < CMAX) m_stall++;
                if (e.if_id_flush == 1 && m_flush < CMAX) m_flush++;
            end
        end
        #1;
    endtask

    task automatic set_load(input logic [4:0] rt);
        ex_mem_read = 1; ex_rt = rt; id_rs = 5'd5; id_uses_rs = 1; id_is_jr = 1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step();

        // Plain run after reset release.
        idle();
        repeat (3) step();

        // Taken beq beats a simultaneous jr.
        ex_is_beq = 1; ex_beq_taken = 1; id_is_jr = 1; step();
        idle(); step();

        // jr beats j; j alone.
        id_is_j = 1; id_is_jr = 1; step();
        id_is_jr = 0; step();
        idle(); step();

        // Load-use against a jr: three hold cycles, then the jr proceeds.
        clr_stats = 1; step();
        idle(); set_load(5'd5); repeat (LB) step();
        ex_mem_read = 0; step();
        idle(); step();

        // Same pattern with the load targeting $zero: no hazard.
        set_load(5'd0); step();
        idle(); step();

        // Freeze for two cycles in the middle of a load stall.
        clr_stats = 1; step();
        idle(); set_load(5'd5); step();
        idle(); ext_stall = 1; repeat (2) step();
        ext_stall = 0; repeat (2) step();
        repeat (2) step();

        // Drive the stall counter into saturation, then clear it during a freeze.
        quiet = 1;
        ext_stall = 1; repeat (CMAX + 8) step();
        quiet = 0;
        repeat (2) step();
        clr_stats = 1; step();
        clr_stats = 0; ext_stall = 0; step();

        // Reset in the middle of a load stall.
        set_load(5'd5); step();
        idle(); step();
        reset = 0; step();
        idle(); repeat (2) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) != 0);
            ext_stall    = ($urandom_range(0, 7) == 0);
            ex_is_beq    = ($urandom_range(0, 3) == 0);
            ex_beq_taken = $urandom_range(0, 1);
            id_is_j      = ($urandom_range(0, 5) == 0);
            id_is_jr     = ($urandom_range(0, 5) == 0);
            id_uses_rs   = $urandom_range(0, 1);
            id_uses_rt   = $urandom_range(0, 1);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_rt        = 5'($urandom_range(0, 3));
            clr_stats    = ($urandom_range(0, 39) == 0);
            step();
        end

        idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
